// File: rtl/inst_issue_queue.sv
// inst_issue_queue: dual-push/dual-pop circular queue feeding master/slave decode slots
module inst_issue_queue #(
  parameter int DEPTH = 16,
  parameter int EXCEPT_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push_en1,
  input  logic [31:0]         push_inst1,
  input  logic [31:0]         push_pc1,
  input  logic [EXCEPT_W-1:0] push_exc1,
  input  logic                push_en2,
  input  logic [31:0]         push_inst2,
  input  logic [31:0]         push_pc2,
  input  logic [EXCEPT_W-1:0] push_exc2,
  input  logic                pop_master,
  input  logic                pop_slave,
  output logic                master_valid,
  output logic [31:0]         master_inst,
  output logic [31:0]         master_pc,
  output logic [EXCEPT_W-1:0] master_exc,
  output logic                slave_valid,
  output logic [31:0]         slave_inst,
  output logic [31:0]         slave_pc,
  output logic [EXCEPT_W-1:0] slave_exc,
  output logic [AW:0]         count,
  output logic                full,
  output logic                empty
);
  localparam int EW = 64 + EXCEPT_W;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, slave_idx, wr2_idx;
  logic [AW:0] count_q, count_d, npop_req, npop, npush, free;
  logic acc1, acc2;
  logic [EW-1:0] m_ent, s_ent;
  always_comb begin
    npop_req = (AW+1)'(pop_master) + (AW+1)'(pop_master & pop_slave);
    npop = npop_req > count_q ? count_q : npop_req;
    // slots released by this cycle's pop are reusable in the same cycle
    free = (AW+1)'(DEPTH) - count_q + npop;
    acc1 = push_en1 && free >= (AW+1)'(1);
    acc2 = push_en2 && free >= (acc1 ? (AW+1)'(2) : (AW+1)'(1));
    npush = (AW+1)'(acc1) + (AW+1)'(acc2);
    wr2_idx = acc1 ? tail_q + AW'(1) : tail_q;
    head_d = flush ? '0 : head_q + npop[AW-1:0];
    tail_d = flush ? '0 : tail_q + npush[AW-1:0];
    count_d = flush ? '0 : count_q + npush - npop;
    slave_idx = head_q + AW'(1);
    m_ent = count_q != '0 ? mem[head_q] : '0;
    s_ent = count_q >= (AW+1)'(2) ? mem[slave_idx] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc1) mem[tail_q] <= {push_exc1, push_pc1, push_inst1};
    if (acc2) mem[wr2_idx] <= {push_exc2, push_pc2, push_inst2};
  end
  assign master_valid = count_q != '0;
  assign slave_valid = count_q >= (AW+1)'(2);
  assign {master_exc, master_pc, master_inst} = m_ent;
  assign {slave_exc, slave_pc, slave_inst} = s_ent;
  assign count = count_q;
  assign full = count_q > (AW+1)'(DEPTH - 2);
  assign empty = count_q == '0;
endmodule

// File: tb/tb_inst_issue_queue.sv
// tb_inst_issue_queue: directed checks of push/pop, wrap, overflow, flush and async reset
module tb_inst_issue_queue;
  logic clk = 0, rst = 1, flush = 0;
  logic push_en1 = 0, push_en2 = 0, pop_master = 0, pop_slave = 0;
  logic [31:0] push_inst1 = 0, push_pc1 = 0, push_inst2 = 0, push_pc2 = 0;
  logic [7:0] push_exc1 = 0, push_exc2 = 0;
  logic master_valid, slave_valid, full, empty;
  logic [31:0] master_inst, master_pc, slave_inst, slave_pc;
  logic [7:0] master_exc, slave_exc;
  logic [4:0] count;
  int errors = 0, checks = 0;

  inst_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_en1(push_en1), .push_inst1(push_inst1), .push_pc1(push_pc1), .push_exc1(push_exc1),
    .push_en2(push_en2), .push_inst2(push_inst2), .push_pc2(push_pc2), .push_exc2(push_exc2),
    .pop_master(pop_master), .pop_slave(pop_slave),
    .master_valid(master_valid), .master_inst(master_inst), .master_pc(master_pc), .master_exc(master_exc),
    .slave_valid(slave_valid), .slave_inst(slave_inst), .slave_pc(slave_pc), .slave_exc(slave_exc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock of stimulus; pc is inst<<2 and exc is inst[7:0]
  task automatic cyc(input logic e1, input logic e2, input logic pm, input logic ps,
                     input logic fl, input logic [31:0] i1, input logic [31:0] i2);
    push_en1 = e1; push_inst1 = i1; push_pc1 = i1 << 2; push_exc1 = i1[7:0];
    push_en2 = e2; push_inst2 = i2; push_pc2 = i2 << 2; push_exc2 = i2[7:0];
    pop_master = pm; pop_slave = ps; flush = fl;
    @(posedge clk); #1;
    push_en1 = 0; push_en2 = 0; pop_master = 0; pop_slave = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic push15();
    for (int k = 0; k < 7; k++) cyc(1, 1, 0, 0, 0, 32'h1000 + 2*k, 32'h1000 + 2*k + 1);
    cyc(1, 0, 0, 0, 0, 32'h100E, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_mvalid", 32'(master_valid), 0);
    chk("rst_svalid", 32'(slave_valid), 0);
    chk("rst_minst", master_inst, 0);

    // dual push, pc 0x100/0x104
    push_en1 = 1; push_inst1 = 32'hA0; push_pc1 = 32'h100; push_exc1 = 8'h01;
    push_en2 = 1; push_inst2 = 32'hA4; push_pc2 = 32'h104; push_exc2 = 8'h02;
    @(posedge clk); #1;
    push_en1 = 0; push_en2 = 0;
    chk("dual_mpc", master_pc, 32'h100);
    chk("dual_spc", slave_pc, 32'h104);
    chk("dual_count", 32'(count), 2);
    chk("dual_mexc", 32'(master_exc), 1);
    chk("dual_sinst", slave_inst, 32'hA4);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("pop2_empty", 32'(empty), 1);
    chk("pop2_mvalid", 32'(master_valid), 0);
    chk("pop2_minst", master_inst, 0);

    // single issue: A,B then C via entry 2 alone
    cyc(1, 1, 0, 0, 0, 32'hA, 32'hB);
    cyc(0, 1, 0, 0, 0, 0, 32'hC);
    chk("si_count3", 32'(count), 3);
    chk("si_slave_b", slave_inst, 32'hB);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("si_master", master_inst, 32'hB);
    chk("si_slave", slave_inst, 32'hC);
    chk("si_spc", slave_pc, 32'hC << 2);
    chk("si_count2", 32'(count), 2);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("ps_alone_count", 32'(count), 2);
    chk("ps_alone_master", master_inst, 32'hB);
    cyc(0, 0, 1, 1, 1'b0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("overpop_count", 32'(count), 0);

    // async reset mid-stream at count=5
    cyc(1, 1, 0, 0, 0, 1, 2);
    cyc(1, 1, 0, 0, 0, 3, 4);
    cyc(1, 0, 0, 0, 0, 5, 0);
    chk("pre_rst_count", 32'(count), 5);
    #2 rst = 1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_mvalid", 32'(master_valid), 0);
    chk("arst_minst", master_inst, 0);
    @(posedge clk); #1 rst = 0;

    // wrap
    push15();
    chk("w_count15", 32'(count), 15);
    chk("w_full15", 32'(full), 1);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 1, 0, 0, 0);
    chk("w_count1", 32'(count), 1);
    chk("w_full1", 32'(full), 0);
    cyc(1, 1, 0, 0, 0, 32'h100F, 32'h1010);
    cyc(1, 1, 0, 0, 0, 32'h1011, 32'h1012);
    chk("w_count5", 32'(count), 5);
    chk("w_master14", master_inst, 32'h100E);
    chk("w_slave15", slave_inst, 32'h100F);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("w_master0", master_inst, 32'h1010);
    chk("w_slave1", slave_inst, 32'h1011);
    chk("w_count3", 32'(count), 3);

    // full / overflow
    do_reset();
    push15();
    chk("f_full", 32'(full), 1);
    cyc(1, 1, 0, 0, 0, 32'h2001, 32'h2002);
    chk("f_count16", 32'(count), 16);
    chk("f_full16", 32'(full), 1);
    cyc(1, 1, 1, 1, 0, 32'h3001, 32'h3002);
    chk("f_pushpop16", 32'(count), 16);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 1, 0, 0, 0);
    chk("f_count4", 32'(count), 4);
    chk("f_master", master_inst, 32'h100E);
    chk("f_drop2", slave_inst, 32'h2001);

    // flush beats push and pop
    cyc(1, 1, 0, 0, 0, 32'h4001, 32'h4002);
    chk("fl_count6", 32'(count), 6);
    cyc(1, 1, 1, 0, 1, 32'h5001, 32'h5002);
    chk("fl_count", 32'(count), 0);
    chk("fl_mvalid", 32'(master_valid), 0);
    chk("fl_svalid", 32'(slave_valid), 0);
    chk("fl_empty", 32'(empty), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("fl_idle_count", 32'(count), 0);
    chk("fl_idle_minst", master_inst, 0);
    cyc(1, 0, 0, 0, 0, 32'h6001, 0);
    chk("fl_after_master", master_inst, 32'h6001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
